// File: rtl/spi_reg_bridge_pkg.sv
// Purpose: shared types and constants for the SPI command decoder / register file.
// Latency: n/a (definitions only).
// Backpressure: n/a; the SPI byte stream cannot be stalled.
package spi_reg_bridge_pkg;

   // Decoder states; IDLE must stay 0 so o_Busy is a simple compare.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CMD   = 2'd1,
      S_WRITE = 2'd2,
      S_READ  = 2'd3
   } state_t;

   // Command byte bit selecting read (1) or write (0).
   localparam int CMD_RD_BIT = 7;

   // Byte returned on MISO when no read data is pending.
   localparam logic [7:0] IDLE_BYTE_DEF = 8'hF0;

   // Default register file geometry.
   localparam int DEPTH_DEF  = 8;
   localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Purpose: byte-stream and register-export signals between SPI_Slave glue and the bridge.
// Latency: n/a (wiring only).
// Backpressure: none; every i_RX_DV pulse must be consumed in the cycle it arrives.
interface spi_reg_bridge_if #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
);
   logic                 i_SPI_CS_n;
   logic                 i_RX_DV;
   logic [7:0]           i_RX_Byte;
   logic                 o_TX_DV;
   logic [7:0]           o_TX_Byte;
   logic                 o_Wr_Strobe;
   logic [ADDR_W-1:0]    o_Wr_Addr;
   logic [DEPTH*8-1:0]   o_Regs;
   logic                 o_Busy;

   // Side that supplies the CS pin and the received bytes.
   modport master (
      output i_SPI_CS_n, i_RX_DV, i_RX_Byte,
      input  o_TX_DV, o_TX_Byte, o_Wr_Strobe, o_Wr_Addr, o_Regs, o_Busy
   );

   // The bridge itself.
   modport slave (
      input  i_SPI_CS_n, i_RX_DV, i_RX_Byte,
      output o_TX_DV, o_TX_Byte, o_Wr_Strobe, o_Wr_Addr, o_Regs, o_Busy
   );
endinterface

// File: rtl/spi_reg_bridge_cs_sync.sv
// Purpose: 2-flop synchroniser for the raw CS_n pin with rise/fall pulse outputs.
// Latency: an edge on the pin is acted on by the consumer 3 clocks after the pin moves.
// Backpressure: none; pulses are one cycle wide and are not held.
module spi_reg_bridge_cs_sync (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_CS_n,
   output logic o_Rise,
   output logic o_Fall
);

   logic       cs_meta;
   logic       cs_sync;
   logic       cs_sync_d;
   logic [1:0] fill_cnt;
   logic       armed;

   // Synchroniser chain plus one delayed copy for edge detection; idles deasserted (1).
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         cs_sync_d <= 1'b1;
      end else begin
         cs_meta   <= i_CS_n;
         cs_sync   <= cs_meta;
         cs_sync_d <= cs_sync;
      end
   end

   // The chain resets to 1, so a pin already low at reset release would look like
   // a fall. Only arm fall detection once a real synchronised sample shows CS high.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         fill_cnt <= 2'd0;
         armed    <= 1'b0;
      end else begin
         if (fill_cnt != 2'd2) begin
            fill_cnt <= fill_cnt + 2'd1;
         end
         if (fill_cnt == 2'd2 && cs_sync) begin
            armed <= 1'b1;
         end
      end
   end

   assign o_Fall = armed & cs_sync_d & ~cs_sync;
   assign o_Rise = ~cs_sync_d & cs_sync;

endmodule

// File: rtl/spi_reg_bridge.sv
// Purpose: SPI command decoder + auto-incrementing register file exported flat.
// Latency: TX load / write strobe registered, exactly 1 cycle after the triggering i_RX_DV.
// Backpressure: none; bytes arriving in IDLE are dropped, every other byte is consumed.
module spi_reg_bridge
   import spi_reg_bridge_pkg::*;
#(
   parameter int         DEPTH     = DEPTH_DEF,
   parameter int         ADDR_W    = ADDR_W_DEF,
   parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   spi_reg_bridge_if.slave  bus
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_nxt;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] cmd_addr;
   logic [7:0]        regs [DEPTH];
   logic              wr_en;

   logic              cs_rise;
   logic              cs_fall;

   logic              tx_dv_q,     tx_dv_nxt;
   logic [7:0]        tx_byte_q,   tx_byte_nxt;
   logic              wr_strobe_q, wr_strobe_nxt;
   logic [ADDR_W-1:0] wr_addr_q,   wr_addr_nxt;

   spi_reg_bridge_cs_sync u_cs_sync (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_CS_n (bus.i_SPI_CS_n),
      .o_Rise (cs_rise),
      .o_Fall (cs_fall)
   );

   // Address field of the command byte; the bits between it and the R/W bit are ignored.
   assign cmd_addr = bus.i_RX_Byte[ADDR_W-1:0];
   // Natural ADDR_W-bit overflow gives the modulo-DEPTH wrap.
   assign addr_inc = addr + ADDR_ONE;

   // State register.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a CS fall always (re)starts in CMD, a CS rise always ends the
   // transaction; a byte arriving with the rise is still handled by the output logic.
   always_comb begin
      state_nxt = state;
      if (cs_fall) begin
         state_nxt = S_CMD;
      end else if (cs_rise) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_CMD: begin
               if (bus.i_RX_DV) begin
                  state_nxt = bus.i_RX_Byte[CMD_RD_BIT] ? S_READ : S_WRITE;
               end
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   // Output / datapath decode: next values for the registered pulses, the address and the write enable.
   always_comb begin
      addr_nxt      = addr;
      wr_en         = 1'b0;
      tx_dv_nxt     = 1'b0;
      tx_byte_nxt   = tx_byte_q;
      wr_strobe_nxt = 1'b0;
      wr_addr_nxt   = wr_addr_q;
      if (cs_fall) begin
         // Reply to the command byte that is about to be clocked in.
         tx_dv_nxt   = 1'b1;
         tx_byte_nxt = IDLE_BYTE;
      end else if (bus.i_RX_DV) begin
         case (state)
            S_CMD: begin
               addr_nxt = cmd_addr;
               if (bus.i_RX_Byte[CMD_RD_BIT]) begin
                  tx_dv_nxt   = 1'b1;
                  tx_byte_nxt = regs[cmd_addr];
               end
            end
            S_WRITE: begin
               wr_en         = 1'b1;
               wr_strobe_nxt = 1'b1;
               wr_addr_nxt   = addr;
               addr_nxt      = addr_inc;
            end
            S_READ: begin
               // Data byte from the master is a dummy; preload the next register.
               addr_nxt    = addr_inc;
               tx_dv_nxt   = 1'b1;
               tx_byte_nxt = regs[addr_inc];
            end
            default: begin
               addr_nxt = addr;
            end
         endcase
      end
   end

   // Registered outputs and burst address.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         addr        <= '0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= IDLE_BYTE;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         addr        <= addr_nxt;
         tx_dv_q     <= tx_dv_nxt;
         tx_byte_q   <= tx_byte_nxt;
         wr_strobe_q <= wr_strobe_nxt;
         wr_addr_q   <= wr_addr_nxt;
      end
   end

   // Register file; the write lands on the same edge that raises the strobe.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= 8'h00;
         end
      end else if (wr_en) begin
         regs[addr] <= bus.i_RX_Byte;
      end
   end

   // Flat export, reg n at [8n+7:8n].
   for (genvar g = 0; g < DEPTH; g++) begin : g_regs_flat
      assign bus.o_Regs[8*g +: 8] = regs[g];
   end

   assign bus.o_TX_DV     = tx_dv_q;
   assign bus.o_TX_Byte   = tx_byte_q;
   assign bus.o_Wr_Strobe = wr_strobe_q;
   assign bus.o_Wr_Addr   = wr_addr_q;
   assign bus.o_Busy      = (state != S_IDLE);

endmodule
